// File: rtl/lea128_ks_seq.sv
// LEA-128 encryption key schedule: one 192-bit round key per cycle under a valid/ready handshake.
// Optional `LEA_KS_ABORT_EN adds an abort input that drops an in-flight schedule.
module lea128_ks_seq #(
  parameter int unsigned ROUNDS = 24
) (
`ifdef LEA_KS_ABORT_EN
  input  logic         abort,
`endif
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [191:0] rk,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [4:0]   rk_idx,
  output logic         rk_last
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [4:0] LastIdx = 5'(ROUNDS - 1);

  function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] delta_f(input logic [1:0] s);
    logic [31:0] d;
    case (s)
      2'd0:    d = 32'hc3efe9db;
      2'd1:    d = 32'h44626b02;
      2'd2:    d = 32'h79e27c8a;
      default: d = 32'h78df30ec;
    endcase
    return d;
  endfunction

  function automatic logic [4:0] rot_f(input int j);
    logic [4:0] r;
    case (j)
      0:       r = 5'd1;
      1:       r = 5'd3;
      2:       r = 5'd6;
      default: r = 5'd11;
    endcase
    return r;
  endfunction

  state_e      r_state;
  logic [4:0]  r_i;
  logic [31:0] r_t [4];

  state_e      w_state_next;
  logic [4:0]  w_i_next;
  logic [31:0] w_t_next [4];
  logic [31:0] w_t_upd  [4];
  logic [4:0]  w_round;
  logic [31:0] w_delta;
  logic        w_load;

  // One datapath serves both the key load (round 0 from K) and each advance (round i+1 from T).
  always_comb begin
    w_load  = (r_state == StIdle);
    w_round = w_load ? 5'd0 : r_i + 5'd1;
    w_delta = delta_f(w_round[1:0]);
    for (int j = 0; j < 4; j++) begin
      w_t_upd[j] = rol32((w_load ? key[32*j +: 32] : r_t[j]) + rol32(w_delta, w_round + 5'(j)),
                         rot_f(j));
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_i_next     = r_i;
    for (int j = 0; j < 4; j++) begin
      w_t_next[j] = r_t[j];
    end
    case (r_state)
      StIdle: begin
        if (key_valid) begin
          w_state_next = StRun;
          w_i_next     = 5'd0;
          for (int j = 0; j < 4; j++) begin
            w_t_next[j] = w_t_upd[j];
          end
        end
      end
      StRun: begin
        if (rk_ready) begin
          if (r_i == LastIdx) begin
            w_state_next = StIdle;
          end else begin
            w_i_next = r_i + 5'd1;
            for (int j = 0; j < 4; j++) begin
              w_t_next[j] = w_t_upd[j];
            end
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
`ifdef LEA_KS_ABORT_EN
    // A coincident handshake still advances above; abort only overrides the state.
    if (r_state == StRun && abort) begin
      w_state_next = StIdle;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_i     <= 5'd0;
      for (int j = 0; j < 4; j++) begin
        r_t[j] <= 32'd0;
      end
    end else begin
      r_state <= w_state_next;
      r_i     <= w_i_next;
      for (int j = 0; j < 4; j++) begin
        r_t[j] <= w_t_next[j];
      end
    end
  end

  always_comb begin
    key_ready = (r_state == StIdle);
    rk_valid  = (r_state == StRun);
    rk        = {r_t[1], r_t[3], r_t[1], r_t[2], r_t[1], r_t[0]};
    rk_idx    = r_i;
    rk_last   = (r_state == StRun) && (r_i == LastIdx);
  end

endmodule

// File: doc/lea128_ks_seq.md
LEA128_KS_SEQ -- requirements
Module: lea128_ks_seq

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: key  input  128  master key; K0=key[31:0], K1=key[63:32], K2=key[95:64], K3=key[127:96].
REQ-005 SHALL have ports: key_valid  input  1, and key_ready  output  1; together they form the key-load handshake.
REQ-006 SHALL have port: rk  output  192  round key; word0=rk[31:0] ... word5=rk[191:160].
REQ-007 SHALL have ports: rk_valid  output  1, and rk_ready  input  1; together they form the round-key handshake.
REQ-008 SHALL have port: rk_idx  output  5  round index of rk, 0..23.
REQ-009 SHALL have port: rk_last  output  1  high while rk_idx==23 and rk_valid is high.
REQ-010 SHALL have parameter: ROUNDS, default 24, number of round keys emitted; legal range 1..24.

Function
REQ-011 SHALL hold four 32-bit state words T0..T3, a 5-bit round counter i, and states IDLE and RUN.
REQ-012 SHALL assert key_ready only in IDLE; key is accepted on the cycle where key_valid and key_ready are both high.
REQ-013 SHALL, on key accept, load Tj <= ROL(Kj + ROL(delta[0], j), r_j) with r = (1, 3, 6, 11), set i=0, and enter RUN.
REQ-014 SHALL assert rk_valid exactly 1 cycle after key accept.
REQ-015 SHALL use deltas: delta[0]=c3efe9db, delta[1]=44626b02, delta[2]=79e27c8a, delta[3]=78df30ec (hex).
REQ-016 SHALL drive, in RUN: rk_valid=1, rk={T1,T3,T1,T2,T1,T0} (word5..word0), rk_idx=i; rk is a function of registers only.
REQ-017 SHALL, on an rk handshake with i<ROUNDS-1, set i <= i+1 and update each Tj <= ROL(Tj + ROL(delta[(i+1) mod 4], i+1+j), r_j).
REQ-018 SHALL perform all additions modulo 2^32; rotation amounts are taken mod 32.
REQ-019 SHALL, on an rk handshake with i==ROUNDS-1, return to IDLE, with key_ready high on the next cycle.
REQ-020 SHALL hold rk, rk_idx and rk_valid stable while rk_valid=1 and rk_ready=0; no backpressure limit applies.
REQ-021 SHALL ignore key_valid in RUN; a new key is never accepted mid-schedule.
REQ-022 SHALL sustain a throughput of one round key per cycle when rk_ready is held high: 24 keys in 24 consecutive cycles.

Reset
REQ-023 SHALL, when rst=1, force state IDLE, T0..T3=0, i=0, rk_valid=0, rk_last=0, key_ready=1 on the next edge.
REQ-024 SHALL, on reset mid-schedule, abandon the schedule; the next key accept restarts at round 0.
REQ-025 SHALL give rst priority over all handshakes that occur in the same cycle.

Configuration
REQ-026 SHALL, when macro LEA_KS_ABORT_EN is defined, add port abort (input, 1); abort=1 in RUN returns to IDLE next cycle with rk_valid=0 and T preserved.
REQ-027 SHALL, when abort coincides with an rk handshake, complete the handshake first and then go to IDLE.
REQ-028 SHALL, without LEA_KS_ABORT_EN, omit the abort port; a schedule then ends only by completion or reset.

Verification
REQ-029 SHALL verify: key=f0e1d2c3_b4a59687_78695a4b_3c2d1e0f, rk_ready=1 -> rk_idx=0 rk word0..5 = 003a0fd4,02497010,194f7db1,02497010,090d0883,02497010.
REQ-030 SHALL verify: the same key, rk_ready=1 throughout -> 24 consecutive rk_valid cycles, rk_last only at idx 23, key_ready high 1 cycle later, all 24 keys matching the software model.
REQ-031 SHALL verify: rk_ready toggled randomly (about 50%) -> rk sequence identical to REQ-030, with rk stable across every stall cycle.
REQ-032 SHALL verify: key_valid pulsed with key=0 while in RUN at idx 5 -> no effect; sequence continues at idx 6.
REQ-033 SHALL verify: rst asserted at idx 10, then a new key -> rk_valid=0 one cycle after rst; the new schedule starts at idx 0 with correct RK0.
REQ-034 SHALL verify, under LEA_KS_ABORT_EN: abort at idx 3 with rk_ready=0 -> IDLE next cycle, rk_valid=0, key_ready=1.
